// File: rtl/sobol_int_to_fp_pipe.sv
// Unsigned integer to {exponent, mantissa} float converter, 2-stage valid/ready pipeline.
// Define SOBOL_FP_ROUND_EN for round-half-up with mantissa carry/saturation; default truncates.
module sobol_int_to_fp_pipe #(
  parameter int IN_W  = 32,
  parameter int MAN_W = 11,
  parameter int EXP_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] out_data,
  output logic [15:0]            conv_cnt
);

  localparam int OUT_W = EXP_W + MAN_W;

  if ((2 ** EXP_W) < IN_W) begin : g_exp_w_chk
    $error("EXP_W too small to encode every bit index of IN_W");
  end
  if (IN_W < 16 || IN_W > 64) begin : g_in_w_chk
    $error("IN_W out of range 16..64");
  end
  if (MAN_W < 4 || MAN_W > IN_W - 1) begin : g_man_w_chk
    $error("MAN_W out of range 4..IN_W-1");
  end

  // Index of the top set bit, floored at MAN_W-1 so small inputs keep a full-width mantissa.
  function automatic logic [EXP_W-1:0] lead_one(input logic [IN_W-1:0] d);
    logic [EXP_W-1:0] e;
    e = EXP_W'(MAN_W - 1);
    for (int i = MAN_W; i < IN_W; i++)
      if (d[i]) e = EXP_W'(i);
    return e;
  endfunction

  function automatic logic [OUT_W-1:0] pack_fp(input logic [IN_W-1:0] d,
                                               input logic [EXP_W-1:0] e);
    logic [EXP_W-1:0] shamt;
    logic [MAN_W-1:0] mant;
    logic [EXP_W-1:0] e_out;
`ifdef SOBOL_FP_ROUND_EN
    logic             rnd;
    logic [MAN_W:0]   sum;
`endif
    shamt = e - EXP_W'(MAN_W - 1);
    mant  = MAN_W'(d >> shamt);
    e_out = e;
`ifdef SOBOL_FP_ROUND_EN
    rnd = (shamt != '0) && (((d >> (shamt - EXP_W'(1))) & IN_W'(1)) != '0);
    sum = {1'b0, mant} + (MAN_W + 1)'(rnd);
    // A carry renormalises; at the top exponent there is no room, so clamp instead.
    if (sum[MAN_W]) begin
      if (e == EXP_W'(IN_W - 1)) begin
        mant = '1;
      end else begin
        mant  = {1'b1, {(MAN_W - 1){1'b0}}};
        e_out = e + EXP_W'(1);
      end
    end else begin
      mant = sum[MAN_W-1:0];
    end
`endif
    return {e_out, mant};
  endfunction

  logic             vld_p1, vld_p2;
  logic [IN_W-1:0]  data_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [OUT_W-1:0] data_p2;
  logic             adv_p2;
  logic             in_fire;

  assign adv_p2    = !vld_p2 || out_ready;
  assign in_ready  = !clr && (!vld_p1 || adv_p2);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_p2;
  assign out_data  = data_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (clr) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (adv_p2)   vld_p2 <= vld_p1;
    end
  end

  // Stage 1: capture sample and leading-one position
  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_p1 <= in_data;
      exp_p1  <= lead_one(in_data);
    end
  end

  // Stage 2: normalise into {exponent, mantissa}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 data_p2 <= '0;
    else if (vld_p1 && adv_p2)  data_p2 <= pack_fp(data_p1, exp_p1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       conv_cnt <= '0;
    else if (clr)                     conv_cnt <= '0;
    else if (out_valid && out_ready)  conv_cnt <= conv_cnt + 16'd1;
  end

endmodule

// File: tb/tb_sobol_int_to_fp_pipe.sv
// Bench for sobol_int_to_fp_pipe: directed cases plus randomized traffic against an arithmetic model.
module tb_sobol_int_to_fp_pipe;
  localparam int IN_W  = 32;
  localparam int MAN_W = 11;
  localparam int EXP_W = 5;

  logic              clk = 1'b0;
  logic              rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [IN_W-1:0]   in_data;
  logic [15:0]       out_data;
  logic [15:0]       conv_cnt;

  always #5 clk = ~clk;

  sobol_int_to_fp_pipe #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .conv_cnt(conv_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Float value by plain arithmetic: exponent = floor(log2 x) floored at MAN_W-1.
  function automatic logic [15:0] ref_conv(input logic [31:0] x);
    longint unsigned xl, v, m;
    int e;
    xl = 64'(x);
    v  = xl;
    e  = 0;
    while (v > 1) begin v = v / 2; e++; end
    if (e < MAN_W - 1) e = MAN_W - 1;
    m = (xl / (64'd2 ** (e - (MAN_W - 1)))) % (64'd2 ** MAN_W);
`ifdef SOBOL_FP_ROUND_EN
    if (e >= MAN_W && ((xl / (64'd2 ** (e - MAN_W))) % 2) == 1) m = m + 1;
    if (m == 64'd2 ** MAN_W) begin
      if (e == IN_W - 1) m = 64'd2 ** MAN_W - 1;
      else begin m = 64'd2 ** (MAN_W - 1); e++; end
    end
`endif
    return 16'(longint'(e) * (2 ** MAN_W) + longint'(m));
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] cnt_ref = '0;
  bit          mon_en = 1'b0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_hold) check("hold_stable", {out_valid, out_data}, {1'b1, prev_data});
      check("in_ready_occ", in_ready, (!clr && (exp_q.size() < 2 || out_ready)));
      if (clr) begin
        exp_q.delete();
        cnt_ref   = '0;
        prev_hold = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
          else check("out_data", out_data, exp_q.pop_front());
          check("conv_cnt", conv_cnt, cnt_ref);
          cnt_ref = cnt_ref + 16'd1;
        end
        if (in_valid && in_ready) exp_q.push_back(ref_conv(in_data));
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [31:0] d, input logic [15:0] e, input string tag);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check(tag, out_data, e);
        got = 1'b1;
        break;
      end
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
    tick();
  endtask

  initial begin
    logic [31:0] vecs[4];
    logic [15:0] exp29[4];
    logic [31:0] d3[3];
    logic [15:0] held_d;
    bit          held;
    int          idx, nout, acc, cyc;

    vecs  = '{32'h0000_0000, 32'h0000_07FF, 32'h0000_0800, 32'h8000_0000};
    exp29 = '{16'h5000, 16'h57FF, 16'h5C00, 16'hFC00};
    d3    = '{32'h0001_2345, 32'h0000_0800, 32'hABCD_EF01};

    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_conv_cnt", conv_cnt, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", in_ready, 1);
    mon_en = 1'b1;

    // back-to-back directed vectors, exact latency
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? vecs[c] : $urandom;
      @(negedge clk);
      if (c < 2) check("lat_no_early", out_valid, 0);
      else if (c < 6) begin
        check("seq_valid", out_valid, 1);
        check("seq_data", out_data, exp29[c-2]);
      end
      tick();
    end
    in_valid = 1'b0;

`ifdef SOBOL_FP_ROUND_EN
    single(32'h0000_0FFF, 16'h6400, "fff_round");
`else
    single(32'h0000_0FFF, 16'h5FFF, "fff_trunc");
`endif
    single(32'hFFFF_FFFF, 16'hFFFF, "all_ones_sat");

    clr = 1'b1; tick(); clr = 1'b0;
    check("cnt_after_clr", conv_cnt, 0);

    // stall: three offered, out_ready low for six cycles
    out_ready = 1'b0; idx = 0; held = 1'b0; held_d = '0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? d3[idx] : 32'h0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        if (held) check("stall_stable", out_data, held_d);
        held = 1'b1; held_d = out_data;
      end
      tick();
    end
    check("stall_accepted", idx, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1; nout = 0;
    for (int c = 0; c < 20 && nout < 3; c++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? d3[idx] : 32'h0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        check("stall_order", out_data, ref_conv(d3[nout]));
        nout++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stall_count", nout, 3);
    check("stall_conv_cnt", conv_cnt, 3);

    // asynchronous reset while holding a valid output
    out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom;
    tick(); in_valid = 1'b0; tick();
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    exp_q.delete(); cnt_ref = '0; prev_hold = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_cnt", conv_cnt, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    tick();
    check("in_ready_after_rst2", in_ready, 1);

    // clear with two samples in flight and one offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom;
    tick(); in_data = $urandom; tick();
    in_data = $urandom; clr = 1'b1;
    #1 check("clr_in_ready", in_ready, 0);
    tick(); clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("clr_no_out", out_valid, 0);
      tick();
    end
    check("clr_conv_cnt", conv_cnt, 0);

    // randomized traffic
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFF : ($urandom >> $urandom_range(0, 32));
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("rand_accepted", acc, 10000);
    check("rand_drained", exp_q.size(), 0);
    check("rand_out_idle", out_valid, 0);
    check("rand_conv_cnt", conv_cnt, 10000 % 65536);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sobol_int_to_fp_pipe.md
SOBOL_INT_TO_FP_PIPE -- requirements
Module: sobol_int_to_fp_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 32: input integer width, legal range 16..64.
REQ-002 SHALL have parameter MAN_W, default 11: mantissa width, explicit leading one, no hidden bit; legal 4..IN_W-1.
REQ-003 SHALL have parameter EXP_W, default 5: exponent width; 2^EXP_W >= IN_W is required, else elaboration error.
REQ-004 SHALL have port clk, input, 1: single clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous flush of all pipeline contents.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, IN_W: unsigned integer (Sobol sample).
REQ-010 SHALL have port out_valid, output, 1: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-012 SHALL have port out_data, output, EXP_W+MAN_W: {exponent, mantissa}, unsigned, no sign bit.
REQ-013 SHALL have port conv_cnt, output, 16: count of completed output transfers.

Function
REQ-014 Exponent e SHALL be the bit index of the most significant one of in_data, floored at MAN_W-1; in_data = 0 gives e = MAN_W-1.
REQ-015 Mantissa SHALL be in_data[e : e-MAN_W+1] (truncation) when rounding is compiled out.
REQ-016 SHALL be a 2-stage pipeline: S1 registers in_data and e (leading-one detect); S2 registers the shifted/rounded out_data.
REQ-017 Latency SHALL be 2 cycles from input transfer (in_valid & in_ready) to out_valid with no stall; throughput 1 sample/cycle.
REQ-018 in_ready SHALL equal !S1_valid | S2 advancing-into-empty | (out_ready & out_valid), i.e. a stage loads when it is empty or its contents move on in the same cycle; combinational from out_ready.
REQ-019 When out_valid=1 and out_ready=0, out_data and out_valid SHALL be held stable; the pipeline holds 2 samples max, then in_ready=0.
REQ-020 Simultaneous out transfer and in transfer with a full pipeline SHALL lose no sample and preserve order.
REQ-021 in_data SHALL be ignored when in_valid=0 or in_ready=0.
REQ-022 clr=1 SHALL clear both stage valids at the next edge, drop in-flight samples, set conv_cnt=0; an input offered in the same cycle is dropped; in_ready SHALL be 0 while clr=1.
REQ-023 conv_cnt SHALL increment on each out_valid & out_ready and wrap from 0xFFFF to 0.

Reset
REQ-024 rst_n=0 SHALL immediately force out_valid=0, out_data=0, conv_cnt=0, both stage valids 0, independent of clk.
REQ-025 in_ready SHALL be 1 from the first edge after rst_n deasserts; reset mid-stream discards all in-flight samples.

Configuration
REQ-026 Macro SOBOL_FP_ROUND_EN SHALL, when defined, enable round-half-up: add in_data[e-MAN_W] (when e >= MAN_W) to the mantissa.
REQ-027 With SOBOL_FP_ROUND_EN, mantissa carry-out SHALL yield mantissa 1 followed by zeros and e+1; if e = IN_W-1 the result SHALL saturate to all-ones mantissa with e unchanged.
REQ-028 Without SOBOL_FP_ROUND_EN, mantissa SHALL be truncated per REQ-015; latency is 2 in both builds.

Verification (defaults IN_W=32, MAN_W=11, EXP_W=5)
REQ-029 Inputs 0x00000000, 0x000007FF, 0x00000800, 0x80000000 back-to-back with out_ready=1 -> out_data 0x5000, 0x57FF, 0x5C00, 0xFC00 on 4 consecutive cycles, first 2 cycles after first input.
REQ-030 Input 0x00000FFF -> 0x5FFF truncating; 0x6400 with SOBOL_FP_ROUND_EN. Input 0xFFFFFFFF -> 0xFFFF in both builds (saturation).
REQ-031 Push 3 samples with out_ready=0 for 6 cycles -> in_ready=0 after 2 accepted, out_data stable; release -> all 3 emerge in order, conv_cnt=3.
REQ-032 Random in_valid/out_ready for 10000 samples vs reference model -> exact match, no loss or duplication, conv_cnt = 10000 mod 65536.
REQ-033 rst_n pulsed low while out_valid=1 -> out_valid=0 asynchronously, conv_cnt=0; clr for 1 cycle with 2 in flight -> nothing emerges, conv_cnt=0.
